// File: rtl/cpu_bus_pkg.sv
// Shared types and widths for the Cpu65EL02 bus arbiter and the CPU/DMA blocks.
package cpu_bus_pkg;
    localparam int OWNER_W      = 3;
    localparam int MAX_MASTERS  = 8;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 8;
    localparam int REDBUS_DEV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ_CPU  = 2'd1,
        ST_GRANTED  = 2'd2,
        ST_HANDBACK = 2'd3
    } arb_state_t;
endpackage

// File: rtl/cpu_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick
    import cpu_bus_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       i_req,
    input  logic [OWNER_W-1:0] i_ptr,
    output logic [OWNER_W-1:0] o_idx,
    output logic               o_valid
);
    logic [N-1:0] w_rot;

    // Rotate so bit 0 is the pointer position; the doubled vector handles the wrap.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        // Descending scan: the smallest offset from the pointer is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                o_idx   = (int'(i_ptr) + k >= N) ? OWNER_W'(int'(i_ptr) + k - N)
                                                 : OWNER_W'(int'(i_ptr) + k);
            end
        end
    end
endmodule

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates the CPU bus between the CPU and NUM_MASTERS external masters with
// bounded tenure and a post-handback holdoff so the CPU always makes progress.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 64,
    parameter int HOLDOFF     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_MASTERS-1:0] i_req,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic                   o_bus_request,
    input  logic                   i_bus_release,
    output logic [OWNER_W-1:0]     o_owner,
    output logic                   o_active
);
    localparam logic [7:0]         TEN_LAST  = 8'(MAX_TENURE - 1);
    localparam logic [OWNER_W-1:0] OWNER_TOP = OWNER_W'(NUM_MASTERS - 1);

    arb_state_t             r_state, w_state_n;
    logic [OWNER_W-1:0]     r_ptr, w_ptr_n;
    logic [OWNER_W-1:0]     r_owner, w_owner_n;
    logic [7:0]             r_tenure, w_tenure_n;
    logic [3:0]             r_holdoff, w_holdoff_n;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_n;
    logic                   r_busreq, w_busreq_n;
    logic                   r_active, w_active_n;

    logic [OWNER_W-1:0]     w_pick_idx;
    logic                   w_pick_valid;
    logic [NUM_MASTERS-1:0] w_owner_oh;
    logic                   w_owner_req;
    logic [OWNER_W-1:0]     w_ptr_inc;

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_owner_oh  = NUM_MASTERS'(1) << r_owner;
    assign w_owner_req = |(i_req & w_owner_oh);
    assign w_ptr_inc   = (r_owner == OWNER_TOP) ? '0 : r_owner + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_tenure  <= '0;
            r_holdoff <= '0;
            r_grant   <= '0;
            r_busreq  <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ptr     <= w_ptr_n;
            r_owner   <= w_owner_n;
            r_tenure  <= w_tenure_n;
            r_holdoff <= w_holdoff_n;
            r_grant   <= w_grant_n;
            r_busreq  <= w_busreq_n;
            r_active  <= w_active_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_owner_n   = r_owner;
        w_tenure_n  = r_tenure;
        w_holdoff_n = r_holdoff;
        w_grant_n   = r_grant;
        w_busreq_n  = r_busreq;
        w_active_n  = r_active;
        case (r_state)
            ST_IDLE: begin
                if (r_holdoff != 4'd0) begin
                    w_holdoff_n = r_holdoff - 4'd1;
                end else if (w_pick_valid) begin
                    w_owner_n  = w_pick_idx;
                    w_active_n = 1'b1;
                    w_busreq_n = 1'b1;
                    w_state_n  = ST_REQ_CPU;
                end
            end
            ST_REQ_CPU: begin
                // An abandoned request wins over a coincident release: never grant a master that has left.
                if (!w_owner_req) begin
                    w_busreq_n = 1'b0;
                    w_ptr_n    = w_ptr_inc;
                    w_state_n  = ST_HANDBACK;
                end else if (i_bus_release) begin
                    w_grant_n  = w_owner_oh;
                    w_tenure_n = '0;
                    w_state_n  = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                w_tenure_n = r_tenure + 8'd1;
                if (!i_bus_release || !w_owner_req || r_tenure == TEN_LAST) begin
                    w_grant_n  = '0;
                    w_busreq_n = 1'b0;
                    w_ptr_n    = w_ptr_inc;
                    w_state_n  = ST_HANDBACK;
                end
            end
            ST_HANDBACK: begin
                if (!i_bus_release) begin
                    w_active_n  = 1'b0;
                    w_holdoff_n = 4'(HOLDOFF);
                    w_state_n   = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign o_grant       = r_grant;
    assign o_bus_request = r_busreq;
    assign o_owner       = r_owner;
    assign o_active      = r_active;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: CPU release model plus a grant scoreboard and directed checks.
module tb_cpu_bus_arbiter;
    localparam int NM = 4;
    localparam int HO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NM-1:0] req = '0;
    logic          bus_release = 1'b0;
    logic [NM-1:0] grant;
    logic          bus_request;
    logic [2:0]    owner;
    logic          active;

    int            n_vec = 0;
    int            n_err = 0;
    int            cpu_cnt = 0;
    logic          cpu_drop = 1'b0;
    logic [NM-1:0] sb_q[$];
    logic [NM-1:0] mon_prev = '0;

    cpu_bus_arbiter #(.NUM_MASTERS(NM), .MAX_TENURE(64), .HOLDOFF(HO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .o_grant       (grant),
        .o_bus_request (bus_request),
        .i_bus_release (bus_release),
        .o_owner       (owner),
        .o_active      (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 40 && grant == '0; i++) tick();
        chk(tag, int'(grant != '0), 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && active; i++) tick();
        chk(tag, int'(active), 0);
        repeat (HO + 1) tick();
    endtask

    // CPU: floats its bus 3 clocks after seeing BusRequest, reclaims one edge after it drops.
    always @(negedge clk) begin
        if (cpu_drop || !bus_request) begin
            bus_release <= 1'b0;
            cpu_cnt     <= 0;
        end else if (cpu_cnt >= 2) begin
            bus_release <= 1'b1;
            cpu_cnt     <= 3;
        end else begin
            cpu_cnt <= cpu_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [NM-1:0] exp_g;
        if ($countones(grant) > 1) chk("onehot", int'(grant), 0);
        if (grant != '0 && mon_prev == '0) begin
            if (sb_q.size() == 0) begin
                chk("grant_unexp", int'(grant), 0);
            end else begin
                exp_g = sb_q.pop_front();
                chk("grant_sb", int'(grant), int'(exp_g));
            end
        end
        mon_prev <= grant;
    end

    initial begin
        int w, gap, falls;
        logic [NM-1:0] prev;
        bit first;

        // 1: reset state, first request latency
        req = 4'b0010;
        repeat (3) tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_busreq", int'(bus_request), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_active", int'(active), 0);
        sb_q.push_back(4'b0010);
        rst_n = 1'b1;
        tick();
        chk("t1_busreq", int'(bus_request), 1);
        chk("t1_owner", int'(owner), 1);
        chk("t1_active", int'(active), 1);
        chk("t1_nogrant", int'(grant), 0);
        tick();
        tick();
        chk("t1_wait", int'(grant), 0);
        tick();
        chk("t1_grant", int'(grant), 4'b0010);
        req = '0;
        tick();
        chk("t1_drop_g", int'(grant), 0);
        chk("t1_drop_br", int'(bus_request), 0);
        tick();
        chk("t1_idle", int'(active), 0);

        // 2: full contention, tenure limit and holdoff spacing from a fresh pointer
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb_q.push_back(4'b0001);
        sb_q.push_back(4'b0010);
        sb_q.push_back(4'b0100);
        sb_q.push_back(4'b1000);
        sb_q.push_back(4'b0001);
        req = 4'b1111;
        w = 0; gap = 0; falls = 0; prev = '0; first = 1'b1;
        for (int c = 0; c < 600 && falls < 5; c++) begin
            tick();
            if (grant != '0) begin
                if (prev == '0 && !first) chk("t2_gap", gap, 9);
                w++;
                gap = 0;
            end else begin
                if (prev != '0) begin
                    chk("t2_width", w, 64);
                    falls++;
                    w = 0;
                    first = 1'b0;
                end
                gap++;
            end
            prev = grant;
        end
        chk("t2_falls", falls, 5);
        req = '0;
        wait_idle("t2_idle");

        // 3: master 2 releases early; pointer then sits at 3
        sb_q.push_back(4'b0100);
        req = 4'b0100;
        wait_grant("t3_grant");
        repeat (9) tick();
        req = '0;
        tick();
        chk("t3_drop_g", int'(grant), 0);
        chk("t3_drop_br", int'(bus_request), 0);
        chk("t3_handback", int'(active), 1);
        tick();
        chk("t3_idle", int'(active), 0);
        sb_q.push_back(4'b1000);
        req = 4'b1111;
        wait_grant("t3_ptr_grant");
        chk("t3_ptr_owner", int'(owner), 3);
        req = '0;
        wait_idle("t3_idle2");

        // 4: master 0 abandons before the CPU releases
        req = 4'b0001;
        for (int i = 0; i < 20 && !bus_request; i++) tick();
        chk("t4_busreq", int'(bus_request), 1);
        chk("t4_owner", int'(owner), 0);
        req = '0;
        tick();
        chk("t4_br_low", int'(bus_request), 0);
        chk("t4_nogrant", int'(grant), 0);
        tick();
        chk("t4_idle", int'(active), 0);
        repeat (HO + 4) tick();
        chk("t4_nogrant2", int'(grant), 0);

        // 5: asynchronous reset mid-tenure
        sb_q.push_back(4'b0010);
        req = 4'b0010;
        wait_grant("t5_grant");
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_g", int'(grant), 0);
        chk("t5_async_br", int'(bus_request), 0);
        chk("t5_async_act", int'(active), 0);
        req = 4'b1001;
        sb_q.push_back(4'b0001);
        tick();
        tick();
        rst_n = 1'b1;
        wait_grant("t5_regrant");
        chk("t5_owner", int'(owner), 0);
        req = '0;
        wait_idle("t5_idle");

        // 6: CPU reclaims the bus during a grant
        sb_q.push_back(4'b0100);
        req = 4'b0100;
        wait_grant("t6_grant");
        repeat (3) tick();
        cpu_drop = 1'b1;
        tick();
        chk("t6_g", int'(grant), 0);
        chk("t6_br", int'(bus_request), 0);
        chk("t6_handback", int'(active), 1);
        tick();
        chk("t6_idle", int'(active), 0);
        req = '0;
        cpu_drop = 1'b0;
        repeat (HO + 2) tick();

        chk("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
